// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button counter bank.
package btn_pkg;

  // Debounce FSM states: two stable levels and two qualification states.
  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  // Timer width able to hold any count up to max_val, with one spare bit
  // so a compare against max_val-1 never sees a truncated constant.
  function automatic int timer_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

  // Larger of two integers, used to size one timer shared by two limits.
  function automatic int max2(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/btn_counter_bank_if.sv
// Button/counter bundle between the counter bank and its user logic.
interface btn_counter_bank_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 4
);

  logic [N_CH-1:0]       btn_raw;
  logic [N_CH-1:0]       dir;
  logic [N_CH-1:0]       clr;
  logic [N_CH-1:0]       db_level;
  logic [N_CH-1:0]       db_tick;
  logic [N_CH*CNT_W-1:0] cnt;
  logic [N_CH-1:0]       wrap;

  // User side: drives buttons and controls, observes debounced state.
  modport master (
    output btn_raw, dir, clr,
    input  db_level, db_tick, cnt, wrap
  );

  // Counter bank side.
  modport slave (
    input  btn_raw, dir, clr,
    output db_level, db_tick, cnt, wrap
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, press tick and
// long-press auto-repeat. Level and tick are registered.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = 2_000_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int REPEAT_EN     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic tick
);

  localparam int T_W = timer_width(DB_CYCLES);
  localparam int H_W = timer_width(max2(HOLD_CYCLES, REPEAT_CYCLES));

  localparam logic [T_W-1:0] T_LAST      = T_W'(DB_CYCLES - 1);
  localparam logic [H_W-1:0] H_HOLD_LAST = H_W'(HOLD_CYCLES - 1);
  localparam logic [H_W-1:0] H_REP_LAST  = H_W'(REPEAT_CYCLES - 1);
  localparam logic           REP_ON      = (REPEAT_EN != 0);

  logic           sync1_r;
  logic           sync2_r;
  db_state_t      state_r;
  db_state_t      state_s;
  logic [T_W-1:0] t_r;
  logic [T_W-1:0] t_s;
  logic [H_W-1:0] h_r;
  logic [H_W-1:0] h_s;
  logic           rep_phase_r;
  logic           rep_phase_s;
  logic           hold_done_s;
  logic           press_s;
  logic           repeat_s;
  logic           level_r;
  logic           tick_r;

  // Two-flop synchroniser; the FSM only ever looks at sync2_r.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Hold timer limit: first HOLD_CYCLES after a press, then REPEAT_CYCLES.
  always_comb begin
    hold_done_s = 1'b0;
    if (rep_phase_r) begin
      hold_done_s = (h_r == H_REP_LAST);
    end else begin
      hold_done_s = (h_r == H_HOLD_LAST);
    end
  end

  // Next-state logic for debounce FSM, debounce timer and hold timer.
  always_comb begin
    state_s     = state_r;
    t_s         = t_r;
    h_s         = h_r;
    rep_phase_s = rep_phase_r;
    press_s     = 1'b0;
    repeat_s    = 1'b0;
    case (state_r)
      ZERO: begin
        h_s         = '0;
        rep_phase_s = 1'b0;
        if (sync2_r) begin
          state_s = WAIT1;
          t_s     = '0;
        end else begin
          state_s = ZERO;
        end
      end
      WAIT1: begin
        if (!sync2_r) begin
          state_s = ZERO;
        end else if (t_r == T_LAST) begin
          state_s     = ONE;
          press_s     = 1'b1;
          h_s         = '0;
          rep_phase_s = 1'b0;
        end else begin
          t_s = t_r + 1'b1;
        end
      end
      ONE: begin
        if (!sync2_r) begin
          state_s = WAIT0;
          t_s     = '0;
        end else if (hold_done_s) begin
          h_s         = '0;
          rep_phase_s = 1'b1;
          repeat_s    = REP_ON;
        end else begin
          h_s = h_r + 1'b1;
        end
      end
      WAIT0: begin
        // Hold timer stays frozen here so a release bounce resumes it.
        if (sync2_r) begin
          state_s = ONE;
        end else if (t_r == T_LAST) begin
          state_s = ZERO;
        end else begin
          t_s = t_r + 1'b1;
        end
      end
      default: begin
        state_s = ZERO;
      end
    endcase
  end

  // State, timers and registered level/tick outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ZERO;
      t_r         <= '0;
      h_r         <= '0;
      rep_phase_r <= 1'b0;
      level_r     <= 1'b0;
      tick_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      t_r         <= t_s;
      h_r         <= h_s;
      rep_phase_r <= rep_phase_s;
      level_r     <= (state_s == ONE) || (state_s == WAIT0);
      tick_r      <= press_s | repeat_s;
    end
  end

  assign level = level_r;
  assign tick  = tick_r;

endmodule

// File: rtl/btn_counter_bank.sv
// N-channel push-button front end: per-channel debounce/auto-repeat feeding
// a CNT_W-bit up/down counter with wrap pulse and synchronous clear.
module btn_counter_bank
  import btn_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 4,
  parameter int DB_CYCLES     = 2_000_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int REPEAT_EN     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  btn_counter_bank_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [N_CH-1:0] level_s;
  logic [N_CH-1:0] tick_s;
  logic [N_CH-1:0] wrap_s;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      logic [CNT_W-1:0] cnt_r;
      logic             wrap_r;

      btn_debounce_ch #(
        .DB_CYCLES     (DB_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .REPEAT_EN     (REPEAT_EN)
      ) u_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (bus.btn_raw[g]),
        .level   (level_s[g]),
        .tick    (tick_s[g])
      );

      // Counter: clear wins over a same-cycle tick; wrap flags the wrapped value.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_r  <= CNT_ZERO;
          wrap_r <= 1'b0;
        end else if (bus.clr[g]) begin
          cnt_r  <= CNT_ZERO;
          wrap_r <= 1'b0;
        end else if (tick_s[g]) begin
          if (bus.dir[g]) begin
            cnt_r  <= cnt_r - 1'b1;
            wrap_r <= (cnt_r == CNT_ZERO);
          end else begin
            cnt_r  <= cnt_r + 1'b1;
            wrap_r <= (cnt_r == CNT_MAX);
          end
        end else begin
          wrap_r <= 1'b0;
        end
      end

      assign bus.cnt[g*CNT_W +: CNT_W] = cnt_r;
      assign wrap_s[g]                 = wrap_r;
    end
  endgenerate

  assign bus.db_level = level_s;
  assign bus.db_tick  = tick_s;
  assign bus.wrap     = wrap_s;

endmodule

// File: tb/tb_btn_counter_bank.sv
// Self-checking bench for btn_counter_bank: N_CH=2, CNT_W=3, DB=4, HOLD=10, REPEAT=3.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_btn_counter_bank;

  localparam int N_CH  = 2;
  localparam int CNT_W = 3;
  localparam int DB    = 4;
  localparam int HOLD  = 10;
  localparam int REP   = 3;
  localparam int NVEC  = 7;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  btn_counter_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  btn_counter_bank #(
    .N_CH          (N_CH),
    .CNT_W         (CNT_W),
    .DB_CYCLES     (DB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .REPEAT_EN     (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] btn;
    logic [1:0] dir;
    int         hold;
    int         ticks0;
    int         ticks1;
    int         wraps0;
    int         wraps1;
    int         cnt0;
    int         cnt1;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tk0, tk1, wr0, wr1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int ch);
    logic [N_CH*CNT_W-1:0] v;
    v = bus.cnt;
    return int'(v[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic chk_all_zero(input string name);
    chk({name, " level"}, int'(bus.db_level), 0);
    chk({name, " tick"},  int'(bus.db_tick),  0);
    chk({name, " cnt"},   int'(bus.cnt),      0);
    chk({name, " wrap"},  int'(bus.wrap),     0);
  endtask

  initial begin
    // {btn, dir, hold, ticks0, ticks1, wraps0, wraps1, cnt0, cnt1}; starts at cnt0=2, cnt1=0
    vecs[0] = '{2'b10, 2'b10,  5, 0, 1, 0, 1, 2, 7};  // ch1 down from 0 wraps to 7
    vecs[1] = '{2'b11, 2'b10,  5, 1, 1, 0, 0, 3, 6};  // simultaneous presses both count
    vecs[2] = '{2'b01, 2'b00,  5, 1, 0, 0, 0, 4, 6};
    vecs[3] = '{2'b01, 2'b00,  5, 1, 0, 0, 0, 5, 6};
    vecs[4] = '{2'b10, 2'b00,  5, 0, 1, 0, 0, 5, 7};
    vecs[5] = '{2'b10, 2'b00,  5, 0, 1, 0, 1, 5, 0};  // ch1 up 7 -> 0 wraps
    vecs[6] = '{2'b10, 2'b10, 18, 0, 3, 0, 1, 5, 5};  // ticks at +7,+17,+20: 0->7->6->5

    rst_n       = 1'b0;
    bus.btn_raw = 2'b00;
    bus.dir     = 2'b00;
    bus.clr     = 2'b00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean press on ch0 held 5 cycles.
    bus.btn_raw = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("t1 tick0",  int'(bus.db_tick[0]),  (k == 7) ? 1 : 0);
      chk("t1 tick1",  int'(bus.db_tick[1]),  0);
      chk("t1 level0", int'(bus.db_level[0]), (k >= 7 && k <= 11) ? 1 : 0);
      if (k == 5) bus.btn_raw = 2'b00;
    end
    chk("t1 cnt0", cnt_of(0), 1);
    chk("t1 cnt1", cnt_of(1), 0);

    // Bounce: ch0 toggles every 2 cycles for 20 cycles.
    bus.btn_raw = 2'b01;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk("t2 tick0",  int'(bus.db_tick[0]),  0);
      chk("t2 level0", int'(bus.db_level[0]), 0);
      bus.btn_raw[0] = (k < 20) ? (((k / 2) % 2) == 0) : 1'b0;
    end
    chk("t2 cnt0", cnt_of(0), 1);

    // Clear ch0, then hold 40 cycles for auto-repeat.
    bus.clr = 2'b01;
    @(negedge clk);
    bus.clr = 2'b00;
    chk("t3 clr cnt0", cnt_of(0), 0);
    bus.btn_raw = 2'b01;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      chk("t3 tick0", int'(bus.db_tick[0]),
          ((k == 7) || (k >= 17 && k <= 41 && ((k - 17) % 3) == 0)) ? 1 : 0);
      chk("t3 wrap0", int'(bus.wrap[0]), (k == 36) ? 1 : 0);
      if (k == 40) bus.btn_raw = 2'b00;
    end
    chk("t3 cnt0",   cnt_of(0), 2);
    chk("t3 level0", int'(bus.db_level[0]), 0);

    // Table of press transactions.
    for (int i = 0; i < NVEC; i++) begin
      tk0 = 0; tk1 = 0; wr0 = 0; wr1 = 0;
      bus.dir     = vecs[i].dir;
      bus.btn_raw = vecs[i].btn;
      for (int k = 1; k <= vecs[i].hold + 12; k++) begin
        @(negedge clk);
        tk0 += int'(bus.db_tick[0]);
        tk1 += int'(bus.db_tick[1]);
        wr0 += int'(bus.wrap[0]);
        wr1 += int'(bus.wrap[1]);
        if (k == vecs[i].hold) bus.btn_raw = 2'b00;
      end
      chk($sformatf("v%0d ticks0", i), tk0, vecs[i].ticks0);
      chk($sformatf("v%0d ticks1", i), tk1, vecs[i].ticks1);
      chk($sformatf("v%0d wraps0", i), wr0, vecs[i].wraps0);
      chk($sformatf("v%0d wraps1", i), wr1, vecs[i].wraps1);
      chk($sformatf("v%0d cnt0", i), cnt_of(0), vecs[i].cnt0);
      chk($sformatf("v%0d cnt1", i), cnt_of(1), vecs[i].cnt1);
      chk($sformatf("v%0d level", i), int'(bus.db_level), 0);
    end
    bus.dir = 2'b00;

    // Clear in the same cycle as a ch0 tick with cnt0=5.
    bus.btn_raw = 2'b01;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 7) begin
        chk("t5 tick0", int'(bus.db_tick[0]), 1);
        chk("t5 cnt0 before", cnt_of(0), 5);
        bus.clr = 2'b01;
      end
      if (k == 8) begin
        chk("t5 cnt0 cleared", cnt_of(0), 0);
        chk("t5 wrap0", int'(bus.wrap[0]), 0);
        bus.clr = 2'b00;
      end
      if (k == 5) bus.btn_raw = 2'b00;
    end
    chk("t5 cnt0 final", cnt_of(0), 0);
    chk("t5 cnt1 final", cnt_of(1), 5);

    // Reset during WAIT1, then during the hold phase of a held button.
    bus.btn_raw = 2'b01;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("t6 rst wait1");
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("t6a tick0", int'(bus.db_tick[0]), (k == 7) ? 1 : 0);
      if (k == 12) rst_n = 1'b0;
    end
    chk("t6 cnt0 pre", cnt_of(0), 1);
    @(negedge clk);
    chk_all_zero("t6 rst hold");
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("t6b tick0", int'(bus.db_tick[0]), (k == 7) ? 1 : 0);
    end
    bus.btn_raw = 2'b00;
    repeat (12) @(negedge clk);
    chk("t6 cnt0 end", cnt_of(0), 1);
    chk("t6 level end", int'(bus.db_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
